spi_minion_frontend: RTL and testbench
======================================

Name: spi_minion_frontend

Overview:
SPI minion front-end that sits directly upstream of the FFT/SPI interconnect on one minion port. It synchronizes raw pad signals (cs, sclk, mosi) into the core clock domain and deserializes fixed-length frames onto a val/rdy receive stream. In parallel, it serializes one word from a val/rdy send stream onto miso. It also flags overflow and framing errors and drives the pad output enable for miso.

Parameters:
NBITS, 32, frame length in bits (MSB first); legal range 2..64
SYNC_STAGES, 2, flip-flop depth of the pad input synchronizers; minimum 2

Ports:
clk  input  1  core clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
spi_cs  input  1  raw pad chip select, active low
spi_sclk  input  1  raw pad serial clock, SPI mode 0
spi_mosi  input  1  raw pad serial data in
spi_miso  output  1  serial data out
spi_miso_oeb  output  1  pad output-enable-bar: 0 = drive miso
recv_msg  output  NBITS  received frame
recv_val  output  1  recv_msg valid
recv_rdy  input  1  downstream accepts recv_msg
send_msg  input  NBITS  word to transmit in next frame
send_val  input  1  send_msg valid
send_rdy  output  1  send_msg consumed this cycle
overflow  output  1  one-cycle pulse: completed frame dropped
frame_err  output  1  one-cycle pulse: frame ended with bit count != NBITS
Parity output (feature only): parity_o  output  1

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: spi_miso=0, spi_miso_oeb=1, recv_val=0, recv_msg=0, send_rdy=0, overflow=0, frame_err=0, bit counter=0, FSM=IDLE. Synchronizer flops reset to cs=1, sclk=0, mosi=0.
- Inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last stage with one extra delayed copy. Define cs_fall, cs_rise, sclk_rise, sclk_fall as single-cycle pulses on the synchronized signals.
- FSM states: IDLE, ACTIVE.
- IDLE -> ACTIVE on cs_fall. In the same cycle:
  - clear the bit counter;
  - load tx_shift = send_val ? send_msg : 0;
  - pulse send_rdy=1 if send_val.
- ACTIVE:
  - sclk_rise: rx_shift = {rx_shift[NBITS-2:0], mosi_sync}; counter increments, saturating at NBITS+1.
  - sclk_fall: tx_shift shifts left one bit, filling with 0.
  - spi_miso = tx_shift[NBITS-1]; spi_miso_oeb=0.
- ACTIVE -> IDLE on cs_rise. cs_rise takes priority over a same-cycle sclk edge, which is ignored.
  - If counter==NBITS and the buffer is empty: the buffer captures rx_shift and recv_val=1 on the next cycle.
  - If counter==NBITS and the buffer is full: pulse overflow for one cycle; the buffer keeps its old word.
  - If counter!=NBITS: pulse frame_err for one cycle; data is discarded.
- IDLE: spi_miso_oeb=1, spi_miso=0. SCLK edges are ignored.
- Receive buffer holds one entry. recv_val clears on the cycle after recv_val && recv_rdy.
  - When dequeue and a capture coincide, the capture succeeds (no overflow).
- Latency: a pad cs rise makes recv_val high SYNC_STAGES+2 clk cycles later.
- Sampling constraint: clk must be at least 4x sclk. Faster sclk is unsupported and no detection is required.
- Reset mid-frame: the frame is abandoned, no pulses are issued, and the FSM returns to IDLE even if pad cs stays low. A new cs_fall is needed to start a frame.

Optional Feature:
SPI_MINION_PARITY_EN
- Defined: adds port parity_o, the XOR of all bits of the word in the receive buffer. It updates together with the buffer capture and resets to 0.
- Undefined: parity_o and its logic are absent.

Decomposition:
- Shared package spi_minion_pkg: FSM state enum {IDLE, ACTIVE}; default constants for NBITS and SYNC_STAGES.
- One sub-module, spi_pad_sync: parameterized by SYNC_STAGES. Synchronizes one pad bit and outputs the synced level plus rise/fall pulses. Instantiated three times (cs, sclk, mosi; mosi edges unused).

Test Plan:
- Reset, then idle -> spi_miso_oeb=1, recv_val=0, spi_miso=0; after reset release, all pulses stay 0 for 20 cycles.
- send_val=1, send_msg=32'hA5A5_0F0F; master clocks 32 bits of mosi=32'h1234_5678 -> miso bits match 32'hA5A5_0F0F MSB-first; send_rdy pulses once at cs_fall; recv_msg=32'h1234_5678 with recv_val=1 exactly SYNC_STAGES+2 cycles after pad cs rise.
- recv_rdy=0; send two full frames (32'h1111_1111, then 32'h2222_2222) -> overflow pulses once after the second frame; recv_msg stays 32'h1111_1111.
- Frame of 31 sclk edges, then a frame of 33 edges -> frame_err pulses once per frame; recv_val stays 0.
- Assert reset at bit 16 of a frame with cs held low -> FSM IDLE; no recv_val or frame_err; a following normal frame of 32'hDEAD_BEEF is received correctly.
- With SPI_MINION_PARITY_EN: receive 32'h0000_0007 -> parity_o=1; receive 32'h0000_0003 -> parity_o=0.

Source files
------------

// File: rtl/spi_minion_pkg.sv
// Shared types and default sizing for the SPI minion front-end.
package spi_minion_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  localparam int DEF_NBITS       = 32;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/spi_pad_sync.sv
// Pad-bit synchronizer with edge pulses derived from the last stage and one delayed copy.
module spi_pad_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pad,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_lvl  = r_sync[SYNC_STAGES-1];
  assign o_rise = o_lvl & ~r_dly;
  assign o_fall = ~o_lvl & r_dly;
endmodule

// File: rtl/spi_minion_frontend.sv
// SPI mode-0 minion: pad sync, frame deserializer to a one-entry val/rdy buffer, miso serializer.
// Optional macro SPI_MINION_PARITY_EN adds parity_o over the buffered word.
module spi_minion_frontend
  import spi_minion_pkg::*;
#(
  parameter int NBITS       = DEF_NBITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oeb,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  input  logic [NBITS-1:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic             overflow,
  output logic             frame_err
`ifdef SPI_MINION_PARITY_EN
  ,output logic            parity_o
`endif
);
  localparam int CW = $clog2(NBITS + 2);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;
  assign w_unused = ^{w_sclk_lvl, w_mosi_rise, w_mosi_fall};

  spi_pad_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .i_pad(spi_cs),
    .o_lvl(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_pad_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .i_pad(spi_sclk),
    .o_lvl(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_pad_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .i_pad(spi_mosi),
    .o_lvl(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [NBITS-1:0] r_tx, r_rx, r_msg;
  logic             r_val, r_end, r_ovf, r_ferr, r_armed;
  logic [SYNC_STAGES:0] r_flush;
  logic             w_start;

  // A low cs seen right after reset is the synchronizer leaving its reset value,
  // not a real select; only accept cs_fall once cs has been observed high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush <= '0;
      r_armed <= 1'b0;
    end else begin
      r_flush <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      r_armed <= r_armed | (r_flush[SYNC_STAGES] & w_cs_lvl);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    spi_miso     = 1'b0;
    spi_miso_oeb = 1'b1;
    case (r_state)
      IDLE: if (w_cs_fall && r_armed) begin
        w_next  = ACTIVE;
        w_start = 1'b1;
      end
      ACTIVE: begin
        spi_miso     = r_tx[NBITS-1];
        spi_miso_oeb = 1'b0;
        if (w_cs_rise) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign send_rdy = w_start & send_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_tx  <= '0;
      r_rx  <= '0;
      r_end <= 1'b0;
    end else begin
      r_end <= 1'b0;
      if (w_start) begin
        r_cnt <= '0;
        r_tx  <= send_val ? send_msg : '0;
      end else if (r_state == ACTIVE && w_cs_rise) begin
        r_end <= 1'b1;
      end else if (r_state == ACTIVE) begin
        if (w_sclk_rise) begin
          r_rx <= {r_rx[NBITS-2:0], w_mosi};
          if (r_cnt != CW'(NBITS + 1)) r_cnt <= r_cnt + 1'b1;
        end
        if (w_sclk_fall) r_tx <= {r_tx[NBITS-2:0], 1'b0};
      end
    end
  end

  // Frame end is resolved one cycle after cs_rise; a same-cycle dequeue frees the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg  <= '0;
      r_val  <= 1'b0;
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
      if (r_val && recv_rdy) r_val <= 1'b0;
      if (r_end) begin
        if (r_cnt != CW'(NBITS)) r_ferr <= 1'b1;
        else if (!r_val || recv_rdy) begin
          r_msg <= r_rx;
          r_val <= 1'b1;
        end else r_ovf <= 1'b1;
      end
    end
  end

  assign recv_msg  = r_msg;
  assign recv_val  = r_val;
  assign overflow  = r_ovf;
  assign frame_err = r_ferr;

`ifdef SPI_MINION_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_par <= 1'b0;
    else if (r_end && r_cnt == CW'(NBITS) && (!r_val || recv_rdy)) r_par <= ^r_rx;
  end
  assign parity_o = r_par;
`endif
endmodule

// File: tb/tb_spi_minion_frontend.sv
// Directed bench for spi_minion_frontend: framing, latency, overflow, framing errors, reset abort.
module tb_spi_minion_frontend;
  localparam int NB = 32;
  localparam int SS = 2;

  logic          clk = 1'b0, reset = 1'b1;
  logic          spi_cs = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic          spi_miso, spi_miso_oeb;
  logic [NB-1:0] recv_msg, send_msg = '0;
  logic          recv_val, recv_rdy = 1'b0, send_val = 1'b0, send_rdy;
  logic          overflow, frame_err;
`ifdef SPI_MINION_PARITY_EN
  logic          parity_o;
`endif

  int checks = 0, errors = 0;
  int n_rdy = 0, n_ovf = 0, n_ferr = 0;
  int b_rdy, b_ovf, b_ferr;
  logic [31:0] mi;

  spi_minion_frontend #(.NBITS(NB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oeb(spi_miso_oeb), .recv_msg(recv_msg),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val),
    .send_rdy(send_rdy), .overflow(overflow), .frame_err(frame_err)
`ifdef SPI_MINION_PARITY_EN
    , .parity_o(parity_o)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send_rdy)  n_rdy++;
    if (overflow)  n_ovf++;
    if (frame_err) n_ferr++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b, output logic m);
    spi_mosi = b;
    tick(4);
    m = spi_miso;
    spi_sclk = 1'b1;
    tick(4);
    spi_sclk = 1'b0;
  endtask

  // n sclk cycles, MSB of the n-bit field first; returns the miso bits seen
  task automatic frame(input logic [63:0] d, input int n, output logic [31:0] m_word);
    logic m;
    m_word = '0;
    spi_cs = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      sbit(d[n-1-i], m);
      m_word = {m_word[30:0], m};
    end
    tick(4);
    spi_cs = 1'b1;
  endtask

  task automatic deq();
    recv_rdy = 1'b1;
    tick(1);
    recv_rdy = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(3);
    chk("rst_oeb", 64'(spi_miso_oeb), 64'd1);
    chk("rst_miso", 64'(spi_miso), 64'd0);
    chk("rst_val", 64'(recv_val), 64'd0);
    chk("rst_msg", 64'(recv_msg), 64'd0);
    chk("rst_rdy", 64'(send_rdy), 64'd0);
    reset = 1'b0;
    tick(20);
    chk("idle_pulses", 64'(n_rdy + n_ovf + n_ferr), 64'd0);
    chk("idle_oeb", 64'(spi_miso_oeb), 64'd1);
    chk("idle_val", 64'(recv_val), 64'd0);

    // full frame both directions, exact capture latency
    send_msg = 32'hA5A5_0F0F;
    send_val = 1'b1;
    frame(64'h1234_5678, NB, mi);
    tick(SS + 1);
    chk("lat_early", 64'(recv_val), 64'd0);
    tick(1);
    chk("lat_val", 64'(recv_val), 64'd1);
    chk("rx_msg", 64'(recv_msg), 64'h1234_5678);
    chk("tx_miso", 64'(mi), 64'hA5A5_0F0F);
    chk("send_rdy_once", 64'(n_rdy), 64'd1);
    send_val = 1'b0;
    tick(4);
    chk("oeb_after", 64'(spi_miso_oeb), 64'd1);
    deq();
    chk("deq_val", 64'(recv_val), 64'd0);

    // overflow: second frame dropped while buffer full
    tick(6);
    b_ovf = n_ovf;
    frame(64'h1111_1111, NB, mi);
    tick(10);
    chk("ovf_first_val", 64'(recv_val), 64'd1);
    chk("ovf_first_msg", 64'(recv_msg), 64'h1111_1111);
    chk("miso_no_send", 64'(mi), 64'd0);
    frame(64'h2222_2222, NB, mi);
    tick(10);
    chk("ovf_pulse", 64'(n_ovf - b_ovf), 64'd1);
    chk("ovf_keep_msg", 64'(recv_msg), 64'h1111_1111);
    chk("ovf_keep_val", 64'(recv_val), 64'd1);
    deq();
    chk("ovf_deq", 64'(recv_val), 64'd0);

    // short and long frames
    tick(6);
    b_ferr = n_ferr;
    frame(64'h7FFF_FFFF, NB - 1, mi);
    tick(10);
    chk("ferr_short", 64'(n_ferr - b_ferr), 64'd1);
    chk("ferr_short_val", 64'(recv_val), 64'd0);
    frame(64'h1_FFFF_FFFF, NB + 1, mi);
    tick(10);
    chk("ferr_long", 64'(n_ferr - b_ferr), 64'd2);
    chk("ferr_long_val", 64'(recv_val), 64'd0);

    // reset in the middle of a frame with cs held low
    b_ferr = n_ferr;
    b_ovf  = n_ovf;
    spi_cs = 1'b0;
    tick(4);
    for (int i = 0; i < 16; i++) begin
      logic m;
      sbit(1'b1, m);
    end
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(20);
    chk("abort_oeb", 64'(spi_miso_oeb), 64'd1);
    chk("abort_val", 64'(recv_val), 64'd0);
    chk("abort_pulses", 64'((n_ferr - b_ferr) + (n_ovf - b_ovf)), 64'd0);
    spi_cs = 1'b1;
    tick(10);
    frame(64'hDEAD_BEEF, NB, mi);
    tick(SS + 2);
    chk("post_abort_val", 64'(recv_val), 64'd1);
    chk("post_abort_msg", 64'(recv_msg), 64'hDEAD_BEEF);
    chk("post_abort_ferr", 64'(n_ferr - b_ferr), 64'd0);
    deq();

`ifdef SPI_MINION_PARITY_EN
    tick(6);
    frame(64'h0000_0007, NB, mi);
    tick(10);
    chk("parity_odd", 64'(parity_o), 64'd1);
    deq();
    tick(6);
    frame(64'h0000_0003, NB, mi);
    tick(10);
    chk("parity_even", 64'(parity_o), 64'd0);
    deq();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
